// File: rtl/fifo_pack_pkg.sv
// rtl/fifo_pack_pkg.sv - shared state encoding and parameter defaults for the word packer
package fifo_pack_pkg;
   typedef enum logic {FILL = 1'b0, OUT = 1'b1} state_e;

   localparam int unsigned BYTES_DEF   = 4;
   localparam int unsigned TIMEOUT_DEF = 16;
endpackage

// File: rtl/idle_timer.sv
// rtl/idle_timer.sv - saturating idle-cycle counter that flags when TIMEOUT-1 is reached
module idle_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // Saturate at LAST so the count never wraps back into a fresh idle window.
   always_comb begin
      cnt_d = cnt_q;
      if (clear)                        cnt_d = '0;
      else if (enable && cnt_q != LAST) cnt_d = cnt_q + TW'(1);
   end

   assign expired = (cnt_q == LAST);
endmodule

// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - packs FIFO bytes into little-endian words with flush and idle-timeout emit
module fifo_word_packer
   import fifo_pack_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned BYTES      = BYTES_DEF,
   parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
   input  logic                          rclk,
   input  logic                          rrst,
   input  logic                          empty,
   input  logic [DATA_WIDTH-1:0]         fifo_data,
   output logic                          r_en,
   input  logic                          flush,
   output logic [DATA_WIDTH*BYTES-1:0]   m_data,
   output logic [BYTES-1:0]              m_keep,
   output logic                          m_valid,
   input  logic                          m_ready
);
   localparam int unsigned CW = $clog2(BYTES) + 1;

   state_e                        state_q, state_d;
   logic                          rd_pend_q;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic [DATA_WIDTH*BYTES-1:0]   data_q, data_d;
   logic [BYTES-1:0]              keep_q, keep_d;
   logic                          in_fill, idle, emit, expired;

   assign in_fill = (state_q == FILL);
   assign idle    = in_fill && (cnt_q != '0) && !rd_pend_q;
   assign emit    = idle && (flush || expired);

   idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
      .clk     (rclk),
      .rst     (rrst),
      .clear   (rd_pend_q || !in_fill),
      .enable  (idle),
      .expired (expired)
   );

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         state_q   <= FILL;
         rd_pend_q <= 1'b0;
         cnt_q     <= '0;
         data_q    <= '0;
         keep_q    <= '0;
      end else begin
         state_q   <= state_d;
         rd_pend_q <= r_en;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         keep_q    <= keep_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      keep_d  = keep_q;
      case (state_q)
         FILL: begin
            if (rd_pend_q) begin
               for (int i = 0; i < int'(BYTES); i++)
                  if (cnt_q == CW'(i)) data_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
               cnt_d = cnt_q + CW'(1);
               if (cnt_d == CW'(BYTES)) begin
                  state_d = OUT;
                  keep_d  = '1;
               end
            end else if (emit) begin
               state_d = OUT;
               for (int i = 0; i < int'(BYTES); i++) keep_d[i] = (CW'(i) < cnt_q);
            end
         end
         OUT: begin
            if (m_ready) begin
               state_d = FILL;
               cnt_d   = '0;
               data_d  = '0;
               keep_d  = '0;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // A read is only issued when its byte still has a free lane once the pending one lands.
   always_comb begin
      r_en    = !rrst && in_fill && !empty && !emit &&
                ((cnt_q + CW'(rd_pend_q)) < CW'(BYTES));
      m_valid = !in_fill;
      m_data  = data_q;
      m_keep  = keep_q;
   end
endmodule

// File: tb/tb_fifo_word_packer.sv
// tb/tb_fifo_word_packer.sv - self-checking bench for fifo_word_packer
module tb_fifo_word_packer;
   localparam int DW = 8;
   localparam int NB = 4;
   localparam int TO = 16;

   logic          rclk = 1'b0;
   logic          rrst, empty, r_en, flush, m_valid, m_ready;
   logic [DW-1:0] fifo_data;
   logic [31:0]   m_data;
   logic [3:0]    m_keep;

   always #5 rclk = ~rclk;

   fifo_word_packer #(.DATA_WIDTH(DW), .BYTES(NB), .TIMEOUT(TO)) dut (
      .rclk      (rclk),
      .rrst      (rrst),
      .empty     (empty),
      .fifo_data (fifo_data),
      .r_en      (r_en),
      .flush     (flush),
      .m_data    (m_data),
      .m_keep    (m_keep),
      .m_valid   (m_valid),
      .m_ready   (m_ready)
   );

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      int          cyc;
   } word_t;

   typedef struct {
      int          n;
      bit          fl;
      logic [31:0] data;
      logic [3:0]  keep;
      int          wait_exp;
   } vec_t;

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   logic [7:0]  fq[$];
   word_t       got[$];
   word_t       expw[$];
   bit          hold_empty = 0;
   bit          prev_hold = 0;
   logic [31:0] prev_data;
   logic [3:0]  prev_keep;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock: model the FIFO read port and record handshakes.
   task automatic step();
      logic  re, em;
      word_t w;
      empty = hold_empty || (fq.size() == 0);
      @(negedge rclk);
      re = r_en;
      em = empty;
      chk("r_en_while_empty", 32'(re && em), 0);
      if (prev_hold) begin
         chk("hold_valid", 32'(m_valid), 1);
         chk("hold_data", m_data, prev_data);
         chk("hold_keep", 32'(m_keep), 32'(prev_keep));
      end
      if (m_valid && m_ready && !rrst) begin
         w.data = m_data; w.keep = m_keep; w.cyc = cyc;
         got.push_back(w);
      end
      prev_hold = m_valid && !m_ready && !rrst;
      prev_data = m_data;
      prev_keep = m_keep;
      @(posedge rclk);
      #1;
      cyc++;
      if (re && !em) fifo_data = fq.pop_front();
   endtask

   task automatic wait_valid(input int bound, output int n);
      n = 0;
      while (!m_valid && n < bound) begin
         step();
         n++;
      end
   endtask

   initial begin
      vec_t        tbl[5];
      logic [31:0] d;
      logic [7:0]  b;
      int          w, nrand, it;
      word_t       e;

      tbl[0] = '{3, 1'b0, 32'h00A3A2A1, 4'h7, TO};
      tbl[1] = '{2, 1'b1, 32'h0000C2C1, 4'h3, 1};
      tbl[2] = '{1, 1'b1, 32'h000000D1, 4'h1, 1};
      tbl[3] = '{4, 1'b0, 32'hE4E3E2E1, 4'hF, 0};
      tbl[4] = '{1, 1'b0, 32'h000000F1, 4'h1, TO};

      rrst = 1; flush = 0; m_ready = 0; empty = 1; fifo_data = '0;
      #1;
      chk("rst_r_en", 32'(r_en), 0);
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_keep", 32'(m_keep), 0);
      repeat (2) @(posedge rclk);
      #1 rrst = 0;

      // Partial/full words closed by timeout, flush or a full lane set.
      for (int i = 0; i < 5; i++) begin
         d = tbl[i].data;
         for (int k = 0; k < tbl[i].n; k++) fq.push_back(d[8*k +: 8]);
         m_ready = 0;
         repeat (tbl[i].n + 1) step();
         flush = tbl[i].fl;
         wait_valid(60, w);
         flush = 0;
         chk($sformatf("tbl%0d_latency", i), 32'(w), 32'(tbl[i].wait_exp));
         chk($sformatf("tbl%0d_data", i), m_data, tbl[i].data);
         chk($sformatf("tbl%0d_keep", i), 32'(m_keep), 32'(tbl[i].keep));
         m_ready = 1;
         step();
         m_ready = 0;
         chk($sformatf("tbl%0d_valid_clear", i), 32'(m_valid), 0);
      end

      flush = 1;
      repeat (4) step();
      chk("flush_empty_ignored", 32'(m_valid), 0);
      flush = 0;

      // Two back-to-back words with downstream always ready.
      got.delete();
      for (int k = 1; k <= 8; k++) begin
         b = 8'(k * 8'h11);
         fq.push_back(b);
      end
      m_ready = 1;
      repeat (20) step();
      m_ready = 0;
      chk("b2b_count", 32'(got.size()), 2);
      if (got.size() >= 2) begin
         chk("b2b_w0", got[0].data, 32'h44332211);
         chk("b2b_k0", 32'(got[0].keep), 32'hF);
         chk("b2b_w1", got[1].data, 32'h88776655);
         chk("b2b_k1", 32'(got[1].keep), 32'hF);
         chk("b2b_spacing", 32'((got[1].cyc - got[0].cyc) <= NB + 2), 1);
      end

      // Backpressure: a held word blocks further reads.
      got.delete();
      for (int k = 0; k < 8; k++) fq.push_back(8'h51 + 8'(k));
      wait_valid(20, w);
      chk("bp_valid", 32'(m_valid), 1);
      for (int k = 0; k < 10; k++) begin
         step();
         chk("bp_r_en", 32'(r_en), 0);
      end
      chk("bp_fifo_level", 32'(fq.size()), 4);
      chk("bp_data", m_data, 32'h54535251);
      m_ready = 1;
      repeat (12) step();
      m_ready = 0;
      chk("bp_count", 32'(got.size()), 2);
      if (got.size() >= 2) chk("bp_w1", got[1].data, 32'h58575655);

      // Reset while a byte is in flight with two lanes filled.
      got.delete();
      for (int k = 0; k < 6; k++) fq.push_back(8'h31 + 8'(k));
      repeat (3) step();
      rrst = 1;
      #1;
      chk("mid_rst_r_en", 32'(r_en), 0);
      chk("mid_rst_m_valid", 32'(m_valid), 0);
      chk("mid_rst_m_data", m_data, 0);
      chk("mid_rst_m_keep", 32'(m_keep), 0);
      prev_hold = 0;
      @(posedge rclk);
      #1 rrst = 0;
      chk("mid_rst_fifo_level", 32'(fq.size()), 3);
      fq.push_back(8'h37);
      wait_valid(20, w);
      chk("mid_rst_next_data", m_data, 32'h37363534);
      chk("mid_rst_next_keep", 32'(m_keep), 32'hF);
      m_ready = 1;
      step();
      m_ready = 0;
      step();

      // Random bytes with empty toggling every cycle and random backpressure.
      got.delete();
      expw.delete();
      nrand = 23;
      for (int k = 0; k < nrand; k += NB) begin
         e.data = '0; e.keep = '0; e.cyc = 0;
         for (int j = 0; j < NB && k + j < nrand; j++) begin
            b = 8'($urandom_range(0, 255));
            fq.push_back(b);
            e.data[8*j +: 8] = b;
            e.keep[j] = 1'b1;
         end
         expw.push_back(e);
      end
      it = 0;
      while (got.size() < expw.size() && it < 3000) begin
         hold_empty = cyc[0];
         m_ready = 1'($urandom_range(0, 1));
         step();
         it++;
      end
      hold_empty = 0;
      m_ready = 0;
      chk("rand_count", 32'(got.size()), 32'(expw.size()));
      for (int k = 0; k < expw.size() && k < got.size(); k++) begin
         chk($sformatf("rand_w%0d_data", k), got[k].data, expw[k].data);
         chk($sformatf("rand_w%0d_keep", k), 32'(got[k].keep), 32'(expw[k].keep));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
